lbp_image_host: RTL and testbench

- Responder/sink at the far end of the LBP engine's image interfaces.
- Holds the grayscale frame loaded from a byte stream and serves it on the gray_* read interface.
- Captures results written on the lbp_* interface into a result memory, and tracks completion, error and timeout status.
- Exposes a readback port so the result frame can be read after the run.

---
 rtl/lbp_image_host.sv | 122 ++++++++++++
 tb/tb_lbp_image_host.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_image_host.sv
// Image-side host for the LBP engine: streams a grayscale frame into memory, serves it
// on the gray_* read port, and captures result writes with completion/error/watchdog status.
module lbp_image_host #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int NPIX    = 16384,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] gray_addr,
    input  logic              gray_req,
    output logic              gray_ready,
    output logic [DATA_W-1:0] gray_data,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic              lbp_valid,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err_oob,
    output logic              err_timeout,
    output logic [ADDR_W:0]   wr_count
);
    localparam int IDX_W = $clog2(NPIX);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]  NPIX_L   = (ADDR_W + 1)'(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  load_cnt_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic              gray_we, lbp_we, gray_in, lbp_in, wd_expire;

    logic [DATA_W-1:0] gray_mem [0:NPIX-1];
    logic [DATA_W-1:0] lbp_mem  [0:NPIX-1];

    // gray_req carries no timing meaning for this host; reads happen every SERVE cycle.
    logic unused_inputs;
    assign unused_inputs = gray_req;

    always_comb begin
        state_next = state_reg;
        load_ready = 1'b0;
        gray_ready = 1'b0;
        done       = 1'b0;
        gray_we    = 1'b0;
        lbp_we     = 1'b0;
        wd_expire  = 1'b0;
        gray_in    = {1'b0, gray_addr} < NPIX_L;
        lbp_in     = {1'b0, lbp_addr} < NPIX_L;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                load_ready = 1'b1;
                gray_we    = load_valid;
                if (load_valid && load_cnt_reg == LAST_IDX) state_next = SERVE;
            end
            SERVE: begin
                gray_ready = 1'b1;
                lbp_we     = lbp_valid && lbp_in;
                wd_expire  = !lbp_valid && wdog_reg == WD_LAST;
                if (finish || wd_expire) state_next = DONE;
            end
            DONE:    done = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            load_cnt_reg <= '0;
            wdog_reg     <= '0;
            wr_count     <= '0;
            err_oob      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                load_cnt_reg <= '0;
                wr_count     <= '0;
                err_oob      <= 1'b0;
                err_timeout  <= 1'b0;
            end
            if (gray_we) load_cnt_reg <= load_cnt_reg + 1'b1;
            if (state_reg == SERVE) begin
                wdog_reg <= lbp_valid ? '0 : wdog_reg + 1'b1;
                if (!gray_in || (lbp_valid && !lbp_in)) err_oob <= 1'b1;
                if (lbp_we && wr_count != '1) wr_count <= wr_count + 1'b1;
                // A finish in the expiry cycle is a clean completion.
                if (wd_expire && !finish) err_timeout <= 1'b1;
            end else begin
                wdog_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gray_we) gray_mem[load_cnt_reg] <= load_data;
        if (lbp_we)  lbp_mem[lbp_addr[IDX_W-1:0]] <= lbp_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gray_data <= '0;
            rd_data   <= '0;
        end else begin
            if (state_reg == SERVE)
                gray_data <= gray_in ? gray_mem[gray_addr[IDX_W-1:0]] : '0;
            rd_data <= ({1'b0, rd_addr} < NPIX_L) ? lbp_mem[rd_addr[IDX_W-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_lbp_image_host.sv
// Randomized bench for lbp_image_host against a frame/result-array model of the host.
module tb_lbp_image_host;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int NP = 16384;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset, start, load_valid, load_ready;
    logic [DW-1:0] load_data, gray_data, lbp_data, rd_data;
    logic [AW-1:0] gray_addr, lbp_addr, rd_addr;
    logic          gray_req, gray_ready, lbp_valid, finish;
    logic          done, err_oob, err_timeout;
    logic [AW:0]   wr_count;

    always #5 clk = ~clk;

    lbp_image_host #(.ADDR_W(AW), .DATA_W(DW), .NPIX(NP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .err_oob(err_oob), .err_timeout(err_timeout), .wr_count(wr_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: frame contents, written results, and run status.
    logic [DW-1:0] gray_ref [NP];
    logic [DW-1:0] lbp_ref [int];
    bit            m_serve, m_done, m_oob, m_to;
    int            m_cnt, idle;
    logic [DW-1:0] m_gd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_serve = 0; m_done = 0; m_oob = 0; m_to = 0;
        m_cnt = 0; idle = 0; m_gd = '0;
    endtask

    task automatic begin_run;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_val("start_load_ready", load_ready, 1);
        check_val("start_wr_count", wr_count, 0);
        check_val("start_done", done, 0);
    endtask

    task automatic load_frame(input bit gaps, input bit rnd, input bit lbp_noise);
        int beats = 0, k = 0, bad_rdy = 0, bad_gr = 0;
        while (beats < NP && k < 3 * NP) begin
            load_valid = gaps ? (k % 3 != 2) : 1'b1;
            load_data  = rnd ? DW'($urandom) : DW'(beats);
            lbp_valid  = lbp_noise;
            lbp_addr   = AW'(5);
            lbp_data   = 8'hC3;
            if (load_ready !== 1'b1) bad_rdy++;
            if (gray_ready !== 1'b0) bad_gr++;
            if (load_valid) begin
                gray_ref[beats] = load_data;
                beats++;
            end
            tick;
            k++;
        end
        load_valid = 1'b0;
        lbp_valid  = 1'b0;
        check_val("load_beats", beats, NP);
        check_val("load_ready_held", bad_rdy, 0);
        check_val("gray_ready_low_in_load", bad_gr, 0);
        check_val("load_ready_drop", load_ready, 0);
        check_val("gray_ready_rise", gray_ready, 1);
        m_serve = 1;
        idle = 0;
    endtask

    task automatic serve_cycle(input logic [AW-1:0] ga, input logic lv, input logic [AW-1:0] la,
                               input logic [DW-1:0] ld, input logic fin);
        gray_addr = ga; lbp_valid = lv; lbp_addr = la; lbp_data = ld; finish = fin;
        if (m_serve) begin
            m_gd = (ga < NP) ? gray_ref[ga] : '0;
            if (ga >= NP) m_oob = 1;
            if (lv) begin
                idle = 0;
                if (la < NP) begin
                    lbp_ref[int'(la)] = ld;
                    if (m_cnt < 2 ** (AW + 1) - 1) m_cnt++;
                end else begin
                    m_oob = 1;
                end
            end else begin
                idle++;
            end
            if (fin) begin
                m_serve = 0; m_done = 1;
            end else if (idle >= TO) begin
                m_serve = 0; m_done = 1; m_to = 1;
            end
        end
        tick;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        check_val($sformatf("gray_data@%0d", ga), gray_data, m_gd);
        check_val("gray_ready", gray_ready, m_serve);
        check_val("done", done, m_done);
        check_val("err_oob", err_oob, m_oob);
        check_val("err_timeout", err_timeout, m_to);
        check_val("wr_count", wr_count, m_cnt);
    endtask

    task automatic readback(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        tick;
        check_val($sformatf("rd_data@%0d", a), rd_data, exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int wc_before;
        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
        gray_addr = '0; gray_req = 1'b1; lbp_addr = '0; lbp_valid = 1'b0;
        lbp_data = '0; finish = 1'b0; rd_addr = '0;
        model_reset;
        repeat (3) tick;
        check_val("rst_load_ready", load_ready, 0);
        check_val("rst_gray_ready", gray_ready, 0);
        check_val("rst_gray_data", gray_data, 0);
        check_val("rst_rd_data", rd_data, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err_oob", err_oob, 0);
        check_val("rst_err_timeout", err_timeout, 0);
        check_val("rst_wr_count", wr_count, 0);
        reset = 1'b0;
        tick;

        // Abort a load at byte 100 with junk data; the next run must reload from 0.
        begin_run;
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data  = 8'hEE ^ DW'(i);
            tick;
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick;
        check_val("midload_rst_load_ready", load_ready, 0);
        check_val("midload_rst_gray_ready", gray_ready, 0);
        reset = 1'b0;
        tick;

        // Run 1: gapped raster load, reads, writes, out-of-range accesses, finish with write.
        model_reset;
        begin_run;
        load_frame(1'b1, 1'b0, 1'b0);
        serve_cycle(AW'(129), 1'b1, AW'(129), 8'hA5, 1'b0);
        check_val("gray_129", gray_data, 8'h81);
        serve_cycle(AW'(258), 1'b1, AW'(129), 8'h3C, 1'b0);
        check_val("gray_258", gray_data, 8'h02);
        serve_cycle(AW'(0), 1'b1, AW'(16), 8'h55, 1'b0);
        for (int i = 1; i < 4; i++) serve_cycle(AW'(i), 1'b1, AW'(300 + i), DW'($urandom), 1'b0);
        wc_before = m_cnt;
        serve_cycle(AW'(16384), 1'b1, AW'(16400), 8'h99, 1'b0);
        check_val("oob_gray_data", gray_data, 0);
        check_val("oob_flag", err_oob, 1);
        check_val("oob_no_count", wr_count, wc_before);
        repeat (150)
            serve_cycle(AW'($urandom_range(0, NP - 1)), $urandom_range(0, 3) != 0,
                        AW'($urandom_range(400, 16000)), DW'($urandom), 1'b0);
        wc_before = m_cnt;
        serve_cycle(AW'($urandom_range(0, NP - 1)), 1'b1, AW'(16254), 8'h7F, 1'b1);
        check_val("finish_done", done, 1);
        check_val("finish_write_counted", wr_count, wc_before + 1);
        // In DONE: start and writes are ignored, gray_data holds.
        start = 1'b1;
        serve_cycle(AW'(5), 1'b1, AW'(16), 8'hAA, 1'b0);
        start = 1'b0;
        serve_cycle(AW'(7), 1'b0, AW'(0), 8'h00, 1'b0);
        readback(AW'(129), 8'h3C);
        readback(AW'(16), 8'h55);
        readback(AW'(16254), 8'h7F);
        readback(AW'(16400), 8'h00);
        foreach (lbp_ref[a]) readback(AW'(a), lbp_ref[a]);

        // Run 2: no result writes, watchdog aborts the run.
        reset = 1'b1; tick; reset = 1'b0;
        model_reset;
        begin_run;
        load_frame(1'b0, 1'b1, 1'b0);
        repeat (TO + 4) serve_cycle(AW'($urandom_range(0, NP - 1)), 1'b0, AW'(0), 8'h00, 1'b0);
        check_val("timeout_flag", err_timeout, 1);
        check_val("timeout_done", done, 1);
        check_val("timeout_gray_ready", gray_ready, 0);

        // Run 3: writes during LOAD are ignored; finish coincides with watchdog expiry.
        reset = 1'b1; tick; reset = 1'b0;
        model_reset;
        begin_run;
        load_frame(1'b0, 1'b1, 1'b1);
        check_val("load_writes_ignored", wr_count, 0);
        repeat (TO - 1) serve_cycle(AW'($urandom_range(0, NP - 1)), 1'b0, AW'(0), 8'h00, 1'b0);
        serve_cycle(AW'($urandom_range(0, NP - 1)), 1'b0, AW'(0), 8'h00, 1'b1);
        check_val("finish_vs_wdog_done", done, 1);
        check_val("finish_vs_wdog_to", err_timeout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
